// File: rtl/frame_sched.sv
// Frame sequencer: freezes per-frame turn data, then runs the sprite pre-pass and the ray-cast pass.
// Registered outputs, except busy, which decodes the state. Ticks that arrive while busy are dropped and flagged.
module frame_sched #(
    parameter int TIMEOUT = 262144
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        cfg_valid,
    input  logic [79:0] cfg_angle,
    input  logic [15:0] cfg_pos_x,
    input  logic [15:0] cfg_pos_y,
    output logic [79:0] angle,
    output logic [15:0] map_pos_x,
    output logic [15:0] map_pos_y,
    output logic        sprite_start,
    input  logic        sprite_done,
    output logic        cast_start,
    input  logic        cast_done,
    output logic        busy,
    output logic        frame_overrun,
    output logic        timeout_err,
    input  logic        err_clr,
    output logic [15:0] frame_cnt
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SPRITE_KICK,
        SPRITE_WAIT,
        CAST_KICK,
        CAST_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [79:0]   sh_angle;
    logic [15:0]   sh_pos_x, sh_pos_y;
    logic          accept, tmo, frame_done, ovr_set;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        tmo        = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    accept    = 1'b1;
                    state_nxt = SPRITE_KICK;
                end
            end
            SPRITE_KICK: begin
                cnt_nxt   = '0;
                state_nxt = SPRITE_WAIT;
            end
            SPRITE_WAIT: begin
                if (sprite_done) begin
                    state_nxt = CAST_KICK;
                end else if (cnt == CNT_MAX) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CAST_KICK: begin
                cnt_nxt   = '0;
                state_nxt = CAST_WAIT;
            end
            CAST_WAIT: begin
                if (cast_done) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt == CNT_MAX) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any tick outside IDLE is an overrun, including the cycle CAST_WAIT completes.
    assign ovr_set = frame_start && (state != IDLE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sh_angle      <= '0;
            sh_pos_x      <= '0;
            sh_pos_y      <= '0;
            angle         <= '0;
            map_pos_x     <= '0;
            map_pos_y     <= '0;
            sprite_start  <= 1'b0;
            cast_start    <= 1'b0;
            frame_overrun <= 1'b0;
            timeout_err   <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            sprite_start <= (state_nxt == SPRITE_KICK);
            cast_start   <= (state_nxt == CAST_KICK);
            if (cfg_valid) begin
                sh_angle <= cfg_angle;
                sh_pos_x <= cfg_pos_x;
                sh_pos_y <= cfg_pos_y;
            end
            // Same-cycle cfg write bypasses the shadow so the frame sees the newest data.
            if (accept) begin
                angle     <= cfg_valid ? cfg_angle : sh_angle;
                map_pos_x <= cfg_valid ? cfg_pos_x : sh_pos_x;
                map_pos_y <= cfg_valid ? cfg_pos_y : sh_pos_y;
            end
            frame_overrun <= ovr_set | (frame_overrun & ~err_clr);
            timeout_err   <= tmo | (timeout_err & ~err_clr);
            frame_cnt     <= frame_cnt + {15'd0, frame_done};
        end
    end
endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: a vector table for a short frame with overruns, plus sequences
// for the long nominal frame, shadow isolation, timeout (separate TIMEOUT=16 instance), mid-frame reset and wrap.
module tb_frame_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start, cfg_valid, sprite_done, cast_done, err_clr;
    logic [79:0] cfg_angle;
    logic [15:0] cfg_pos_x, cfg_pos_y;

    logic [79:0] angle;
    logic [15:0] map_pos_x, map_pos_y, frame_cnt;
    logic        sprite_start, cast_start, busy, frame_overrun, timeout_err;

    logic [79:0] t_angle;
    logic [15:0] t_map_pos_x, t_map_pos_y, t_frame_cnt;
    logic        t_sprite_start, t_cast_start, t_busy, t_frame_overrun, t_timeout_err;

    int tests = 0;
    int fails = 0;
    int ss_n = 0, cs_n = 0, tcs_n = 0;

    always #5 clk = ~clk;

    frame_sched dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cfg_valid(cfg_valid),
        .cfg_angle(cfg_angle), .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
        .angle(angle), .map_pos_x(map_pos_x), .map_pos_y(map_pos_y),
        .sprite_start(sprite_start), .sprite_done(sprite_done),
        .cast_start(cast_start), .cast_done(cast_done), .busy(busy),
        .frame_overrun(frame_overrun), .timeout_err(timeout_err),
        .err_clr(err_clr), .frame_cnt(frame_cnt)
    );

    frame_sched #(.TIMEOUT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .cfg_valid(cfg_valid),
        .cfg_angle(cfg_angle), .cfg_pos_x(cfg_pos_x), .cfg_pos_y(cfg_pos_y),
        .angle(t_angle), .map_pos_x(t_map_pos_x), .map_pos_y(t_map_pos_y),
        .sprite_start(t_sprite_start), .sprite_done(sprite_done),
        .cast_start(t_cast_start), .cast_done(cast_done), .busy(t_busy),
        .frame_overrun(t_frame_overrun), .timeout_err(t_timeout_err),
        .err_clr(err_clr), .frame_cnt(t_frame_cnt)
    );

    always @(negedge clk) begin
        if (sprite_start) ss_n++;
        if (cast_start) cs_n++;
        if (t_cast_start) tcs_n++;
    end

    typedef struct packed {
        logic        fs, sd, cd, ec;
        logic        ss, cs, bz, ovr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [16];

    localparam logic [79:0] A1 = 80'h0100_0000_0000_00A8_0100;
    localparam logic [79:0] A2 = 80'h00F0_0010_FFF0_0090_0120;
    localparam logic [79:0] A3 = 80'h1234_5678_9ABC_DEF0_0F0F;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start = 0; cfg_valid = 0; sprite_done = 0; cast_done = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk) rst_n = 0;
        @(negedge clk);
        @(negedge clk) rst_n = 1;
        step();
    endtask

    task automatic load_cfg(input logic [79:0] a, input logic [15:0] x, input logic [15:0] y);
        cfg_valid = 1; cfg_angle = a; cfg_pos_x = x; cfg_pos_y = y;
        step();
        cfg_valid = 0;
    endtask

    task automatic run_frame();
        frame_start = 1; step(); frame_start = 0;
        step();
        sprite_done = 1; step(); sprite_done = 0;
        step();
        cast_done = 1; step(); cast_done = 0;
    endtask

    initial begin
        int ss0, cs0;
        //        fs sd cd ec  ss cs bz ovr cnt
        vecs[0]  = {4'b1000, 4'b1010, 16'd0};
        vecs[1]  = {4'b0000, 4'b0010, 16'd0};
        vecs[2]  = {4'b0010, 4'b0010, 16'd0};
        vecs[3]  = {4'b0100, 4'b0110, 16'd0};
        vecs[4]  = {4'b0000, 4'b0010, 16'd0};
        vecs[5]  = {4'b1000, 4'b0011, 16'd0};
        vecs[6]  = {4'b0001, 4'b0010, 16'd0};
        vecs[7]  = {4'b1001, 4'b0011, 16'd0};
        vecs[8]  = {4'b0001, 4'b0010, 16'd0};
        vecs[9]  = {4'b1010, 4'b0001, 16'd1};
        vecs[10] = {4'b1000, 4'b1011, 16'd1};
        vecs[11] = {4'b0001, 4'b0010, 16'd1};
        vecs[12] = {4'b0100, 4'b0110, 16'd1};
        vecs[13] = {4'b0000, 4'b0010, 16'd1};
        vecs[14] = {4'b0010, 4'b0000, 16'd2};
        vecs[15] = {4'b0000, 4'b0000, 16'd2};

        cfg_angle = '0; cfg_pos_x = '0; cfg_pos_y = '0;
        idle_inputs();
        rst_n = 0;
        #3;
        check("reset_outs", {angle, map_pos_x}, 96'd0);
        check("reset_ctl", {map_pos_y, sprite_start, cast_start, busy, frame_overrun, timeout_err, frame_cnt},
              {16'd0, 5'd0, 16'd0});
        do_reset();

        // Nominal frame with long sprite and cast passes.
        load_cfg(A1, 16'h0380, 16'h0240);
        frame_start = 1; step(); frame_start = 0;
        check("nom_accept", {sprite_start, cast_start, busy}, 3'b101);
        check("nom_angle", {16'd0, angle}, {16'd0, A1});
        check("nom_pos", {map_pos_x, map_pos_y}, {16'h0380, 16'h0240});
        repeat (2600) step();
        sprite_done = 1; step(); sprite_done = 0;
        check("nom_cast_kick", {sprite_start, cast_start, busy}, 3'b011);
        repeat (5000) step();
        check("nom_busy_wait", {busy, cast_start}, 2'b10);
        cast_done = 1; step(); cast_done = 0;
        check("nom_done", {busy, frame_cnt}, {1'b0, 16'd1});
        check("nom_pulses", {ss_n[7:0], cs_n[7:0]}, {8'd1, 8'd1});
        check("nom_hold", {angle, map_pos_x}, {A1, 16'h0380});

        // Shadow isolation: cfg write mid-frame must not reach the outputs until the next accept.
        frame_start = 1; step(); frame_start = 0;
        step();
        load_cfg(A2, 16'h0111, 16'h0222);
        repeat (3) step();
        check("shadow_hold_wait", {angle, map_pos_x}, {A1, 16'h0380});
        sprite_done = 1; step(); sprite_done = 0;
        step();
        cast_done = 1; step(); cast_done = 0;
        check("shadow_hold_idle", {angle, map_pos_y}, {A1, 16'h0240});
        run_frame();
        check("shadow_next", {angle, map_pos_x}, {A2, 16'h0111});
        check("shadow_cnt", {80'd0, frame_cnt}, {80'd0, 16'd3});
        // Same-cycle cfg write on the accepting tick bypasses the shadow.
        cfg_valid = 1; cfg_angle = A3; cfg_pos_x = 16'h0ABC; cfg_pos_y = 16'h0DEF; frame_start = 1;
        step();
        idle_inputs();
        check("bypass", {angle, map_pos_x}, {A3, 16'h0ABC});

        // Vector table: stray done, overruns, err_clr priority, back-to-back accept.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            frame_start = vecs[i].fs; sprite_done = vecs[i].sd;
            cast_done = vecs[i].cd; err_clr = vecs[i].ec;
            step();
            check($sformatf("vec%0d", i),
                  {sprite_start, cast_start, busy, frame_overrun, timeout_err, frame_cnt},
                  {vecs[i].ss, vecs[i].cs, vecs[i].bz, vecs[i].ovr, 1'b0, vecs[i].cnt});
        end
        idle_inputs();

        // Timeout on the TIMEOUT=16 instance: no sprite_done.
        do_reset();
        cs0 = tcs_n;
        frame_start = 1; step(); frame_start = 0;
        check("to_accept", {t_sprite_start, t_busy}, 2'b11);
        step();
        repeat (15) step();
        check("to_before", {t_timeout_err, t_busy}, 2'b01);
        step();
        check("to_abort", {t_timeout_err, t_busy, t_frame_cnt}, {2'b10, 16'd0});
        repeat (3) step();
        check("to_no_cast", {t_cast_start, 8'(tcs_n - cs0)}, 9'd0);
        frame_start = 1; step(); frame_start = 0;
        check("to_reaccept", {t_sprite_start, t_busy, t_timeout_err}, 3'b111);
        err_clr = 1; step(); err_clr = 0;
        check("to_clear", {t_timeout_err}, 1'b0);

        // Reset in CAST_WAIT: asynchronous clear, no start pulses after release.
        do_reset();
        load_cfg(A1, 16'h0380, 16'h0240);
        frame_start = 1; step(); frame_start = 0;
        step();
        sprite_done = 1; step(); sprite_done = 0;
        step();
        frame_start = 1; step(); frame_start = 0;
        check("rst_pre", {busy, frame_overrun, angle != 80'd0}, 3'b111);
        #2 rst_n = 0;
        #1;
        check("rst_async", {angle, map_pos_x}, 96'd0);
        check("rst_async_ctl", {map_pos_y, sprite_start, cast_start, busy, frame_overrun, timeout_err, frame_cnt},
              {16'd0, 5'd0, 16'd0});
        ss0 = ss_n; cs0 = cs_n;
        @(negedge clk);
        @(negedge clk) rst_n = 1;
        repeat (5) step();
        check("rst_no_pulse", {busy, 8'(ss_n - ss0), 8'(cs_n - cs0)}, 17'd0);
        load_cfg(A3, 16'h0007, 16'h0009);
        run_frame();
        check("rst_then_frame", {angle, frame_cnt}, {A3, 16'd1});

        // frame_cnt wrap.
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        check("wrap_pre", {80'd0, frame_cnt}, {80'd0, 16'hFFFF});
        run_frame();
        check("wrap", {busy, frame_cnt}, {1'b0, 16'h0000});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
